// File: rtl/ctrl_seq_hs.sv
// Multi-cycle control sequencer: FETCH/DECODE/ALU/MEM[k]/WREG/UPDPC with ready handshakes.
// Optional bus timeout enabled by defining CTRL_SEQ_MEM_TIMEOUT_EN.
module ctrl_seq_hs #(
    parameter int AW         = 16,
    parameter int MEM_PHASES = 2,
    parameter int PH_W       = 2,
    parameter int TO_CYC     = 16
) (
    input  logic                    clk_i_w,
    input  logic                    rst_i_w,
    input  logic                    en_i_w,
    input  logic                    stall_i_w,
    input  logic                    instr_rdy_i_w,
    input  logic                    mem_rdy_i_w,
    input  logic                    alu_en_i_w,
    input  logic [MEM_PHASES-1:0]   mem_en_i_w,
    input  logic [2*MEM_PHASES-1:0] mem_addr_sel_i_w,
    input  logic [MEM_PHASES-1:0]   mem_wr_rd_i_w,
    input  logic                    wreg_en_i_w,
    input  logic [1:0]              setpc_i_w,
    input  logic [AW-1:0]           pc_i_w,
    input  logic [AW-1:0]           setpc_addr_i_w,
    output logic                    instr_en_o_r,
    output logic                    id_en_o_r,
    output logic                    alu_en_o_r,
    output logic                    mem_en_o_r,
    output logic [1:0]              mem_addr_sel_o_r,
    output logic                    mem_wr_rd_o_r,
    output logic [PH_W-1:0]         mem_phase_o_r,
    output logic                    wreg_en_o_r,
    output logic                    pc_en_o_r,
    output logic                    pc_jmp_o_r,
    output logic [AW-1:0]           pc_addr_o_r,
    output logic                    busy_o_r,
    output logic                    err_o_r
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        ALU    = 4'd3,
        MEM    = 4'd4,
        WREG   = 4'd5,
        UPDPC  = 4'd6,
        STALL  = 4'd7,
        ERR    = 4'd8
    } state_t;

    localparam logic [1:0] SETPC_OFFSET = 2'b01;
    localparam logic [1:0] SETPC_DIRECT = 2'b10;

    if (MEM_PHASES < 1 || MEM_PHASES > 4 || PH_W < 1 || TO_CYC < 2 || TO_CYC > 255) begin : g_param_chk
        $error("ctrl_seq_hs: parameter out of range");
    end

    state_t            r_state;
    state_t            w_seq_state;
    state_t            w_nxt_state;
    state_t            w_tail_state;
    logic [PH_W-1:0]   w_nxt_phase;
    logic [PH_W:0]     w_first;
    logic [PH_W:0]     w_after;
    logic [1:0]        w_nxt_sel;
    logic              w_nxt_wr;
    logic              w_nxt_jmp;
    logic [AW-1:0]     w_nxt_addr;

    // Returns {found, index} of the lowest enabled phase at or above start.
    function automatic logic [PH_W:0] find_phase(input logic [MEM_PHASES-1:0] mask, input int start);
        logic [PH_W:0] res;
        res = '0;
        for (int j = MEM_PHASES - 1; j >= 0; j--) begin
            res = (mask[j] && (j >= start)) ? {1'b1, PH_W'(j)} : res;
        end
        return res;
    endfunction

    // Sequencing decision, ignoring the timeout override.
    always_comb begin
        w_seq_state  = r_state;
        w_nxt_phase  = mem_phase_o_r;
        w_first      = find_phase(mem_en_i_w, 0);
        w_after      = find_phase(mem_en_i_w, int'(mem_phase_o_r) + 1);
        w_tail_state = wreg_en_i_w ? WREG : UPDPC;
        case (r_state)
            IDLE:   w_seq_state = stall_i_w ? STALL : FETCH;
            FETCH:  w_seq_state = instr_rdy_i_w ? DECODE : FETCH;
            DECODE: begin
                if (alu_en_i_w) begin
                    w_seq_state = ALU;
                end else if (w_first[PH_W]) begin
                    w_seq_state = MEM;
                    w_nxt_phase = w_first[PH_W-1:0];
                end else begin
                    w_seq_state = w_tail_state;
                end
            end
            ALU: begin
                if (w_first[PH_W]) begin
                    w_seq_state = MEM;
                    w_nxt_phase = w_first[PH_W-1:0];
                end else begin
                    w_seq_state = w_tail_state;
                end
            end
            MEM: begin
                if (!mem_rdy_i_w) begin
                    w_seq_state = MEM;
                end else if (w_after[PH_W]) begin
                    w_seq_state = MEM;
                    w_nxt_phase = w_after[PH_W-1:0];
                end else begin
                    w_seq_state = w_tail_state;
                end
            end
            WREG:   w_seq_state = UPDPC;
            UPDPC:  w_seq_state = stall_i_w ? STALL : FETCH;
            STALL:  w_seq_state = stall_i_w ? STALL : FETCH;
            ERR:    w_seq_state = ERR;
            default: w_seq_state = IDLE;
        endcase
    end

`ifdef CTRL_SEQ_MEM_TIMEOUT_EN
    logic [7:0] r_wait;
    logic [7:0] w_wait_nxt;
    logic       w_timeout;

    // Wait counter: advances only while FETCH/MEM sees ready low, otherwise clears.
    always_comb begin
        w_wait_nxt = 8'd0;
        w_timeout  = 1'b0;
        if ((r_state == FETCH && !instr_rdy_i_w) || (r_state == MEM && !mem_rdy_i_w)) begin
            if (r_wait == 8'(TO_CYC - 1)) begin
                w_timeout = 1'b1;
            end else begin
                w_wait_nxt = r_wait + 8'd1;
            end
        end else begin
            w_wait_nxt = 8'd0;
        end
    end

    // Wait counter register, frozen while disabled.
    always_ff @(posedge clk_i_w or negedge rst_i_w) begin
        if (!rst_i_w) begin
            r_wait <= 8'd0;
        end else if (en_i_w) begin
            r_wait <= w_wait_nxt;
        end
    end

    assign w_nxt_state = w_timeout ? ERR : w_seq_state;
`else
    assign w_nxt_state = w_seq_state;
`endif

    // Per-phase selects and PC-update values for the state being entered.
    always_comb begin
        w_nxt_sel  = 2'b00;
        w_nxt_wr   = 1'b0;
        w_nxt_jmp  = 1'b0;
        w_nxt_addr = '0;
        for (int k = 0; k < MEM_PHASES; k++) begin
            w_nxt_sel = (w_nxt_phase == PH_W'(k)) ? mem_addr_sel_i_w[2*k +: 2] : w_nxt_sel;
            w_nxt_wr  = (w_nxt_phase == PH_W'(k)) ? mem_wr_rd_i_w[k] : w_nxt_wr;
        end
        if (w_nxt_state == UPDPC) begin
            case (setpc_i_w)
                SETPC_OFFSET: begin
                    w_nxt_jmp  = 1'b1;
                    w_nxt_addr = pc_i_w + setpc_addr_i_w;
                end
                SETPC_DIRECT: begin
                    w_nxt_jmp  = 1'b1;
                    w_nxt_addr = setpc_addr_i_w;
                end
                default: begin
                    w_nxt_jmp  = 1'b0;
                    w_nxt_addr = '0;
                end
            endcase
        end else begin
            w_nxt_jmp  = 1'b0;
            w_nxt_addr = '0;
        end
    end

    // State and registered outputs; everything holds while en_i_w is low.
    always_ff @(posedge clk_i_w or negedge rst_i_w) begin
        if (!rst_i_w) begin
            r_state          <= IDLE;
            instr_en_o_r     <= 1'b0;
            id_en_o_r        <= 1'b0;
            alu_en_o_r       <= 1'b0;
            mem_en_o_r       <= 1'b0;
            mem_addr_sel_o_r <= 2'b00;
            mem_wr_rd_o_r    <= 1'b0;
            mem_phase_o_r    <= '0;
            wreg_en_o_r      <= 1'b0;
            pc_en_o_r        <= 1'b0;
            pc_jmp_o_r       <= 1'b0;
            pc_addr_o_r      <= '0;
            busy_o_r         <= 1'b0;
        end else if (en_i_w) begin
            r_state          <= w_nxt_state;
            instr_en_o_r     <= (w_nxt_state == FETCH);
            id_en_o_r        <= (w_nxt_state == DECODE);
            alu_en_o_r       <= (w_nxt_state == ALU);
            mem_en_o_r       <= (w_nxt_state == MEM);
            mem_addr_sel_o_r <= (w_nxt_state == MEM) ? w_nxt_sel : 2'b00;
            mem_wr_rd_o_r    <= (w_nxt_state == MEM) ? w_nxt_wr : 1'b0;
            mem_phase_o_r    <= (w_nxt_state == MEM) ? w_nxt_phase : '0;
            wreg_en_o_r      <= (w_nxt_state == WREG);
            pc_en_o_r        <= (w_nxt_state == UPDPC);
            pc_jmp_o_r       <= w_nxt_jmp;
            pc_addr_o_r      <= w_nxt_addr;
            busy_o_r         <= (w_nxt_state != IDLE) && (w_nxt_state != STALL) && (w_nxt_state != ERR);
        end
    end

`ifdef CTRL_SEQ_MEM_TIMEOUT_EN
    // Sticky error flag; ERR is only left through reset.
    always_ff @(posedge clk_i_w or negedge rst_i_w) begin
        if (!rst_i_w) begin
            err_o_r <= 1'b0;
        end else if (en_i_w) begin
            err_o_r <= (w_nxt_state == ERR);
        end
    end
`else
    assign err_o_r = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_seq_hs.sv
// Directed bench for ctrl_seq_hs: handshakes, multi-phase memory, PC update, stall, enable freeze, reset, timeout.
module tb_ctrl_seq_hs;
    localparam int AW  = 16;
    localparam int MP  = 2;
    localparam int PHW = 2;

    // {instr, id, alu, mem, wreg, pc_en, pc_jmp, busy, err}
    localparam logic [8:0] E_IDLE  = 9'b000000000;
    localparam logic [8:0] E_FETCH = 9'b100000010;
    localparam logic [8:0] E_DEC   = 9'b010000010;
    localparam logic [8:0] E_ALU   = 9'b001000010;
    localparam logic [8:0] E_MEM   = 9'b000100010;
    localparam logic [8:0] E_WREG  = 9'b000010010;
    localparam logic [8:0] E_UPD   = 9'b000001010;
    localparam logic [8:0] E_UPDJ  = 9'b000001110;
    localparam logic [8:0] E_STALL = 9'b000000000;
    localparam logic [8:0] E_ERR   = 9'b000000001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, en, stall, instr_rdy, mem_rdy, alu_en, wreg_en;
    logic [MP-1:0] mem_en, mem_wr;
    logic [2*MP-1:0] mem_sel;
    logic [1:0] setpc;
    logic [AW-1:0] pc, setpc_addr;
    logic instr_en_o, id_en_o, alu_en_o, mem_en_o, mem_wr_o, wreg_en_o, pc_en_o, pc_jmp_o, busy_o, err_o;
    logic [1:0] mem_sel_o;
    logic [PHW-1:0] mem_phase_o;
    logic [AW-1:0] pc_addr_o;

    int n_checks = 0;
    int n_errs   = 0;

    ctrl_seq_hs #(.AW(AW), .MEM_PHASES(MP), .PH_W(PHW), .TO_CYC(8)) dut (
        .clk_i_w(clk), .rst_i_w(rst_n), .en_i_w(en), .stall_i_w(stall),
        .instr_rdy_i_w(instr_rdy), .mem_rdy_i_w(mem_rdy), .alu_en_i_w(alu_en),
        .mem_en_i_w(mem_en), .mem_addr_sel_i_w(mem_sel), .mem_wr_rd_i_w(mem_wr),
        .wreg_en_i_w(wreg_en), .setpc_i_w(setpc), .pc_i_w(pc), .setpc_addr_i_w(setpc_addr),
        .instr_en_o_r(instr_en_o), .id_en_o_r(id_en_o), .alu_en_o_r(alu_en_o),
        .mem_en_o_r(mem_en_o), .mem_addr_sel_o_r(mem_sel_o), .mem_wr_rd_o_r(mem_wr_o),
        .mem_phase_o_r(mem_phase_o), .wreg_en_o_r(wreg_en_o), .pc_en_o_r(pc_en_o),
        .pc_jmp_o_r(pc_jmp_o), .pc_addr_o_r(pc_addr_o), .busy_o_r(busy_o), .err_o_r(err_o)
    );

    function automatic logic [8:0] st();
        return {instr_en_o, id_en_o, alu_en_o, mem_en_o, wreg_en_o, pc_en_o, pc_jmp_o, busy_o, err_o};
    endfunction

    function automatic logic [4:0] mfld();
        return {mem_sel_o, mem_wr_o, mem_phase_o};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; stall = 1'b0; instr_rdy = 1'b0; mem_rdy = 1'b0;
        alu_en = 1'b0; wreg_en = 1'b0; mem_en = 2'b00; mem_wr = 2'b00; mem_sel = 4'b0000;
        setpc = 2'b00; pc = 16'h0000; setpc_addr = 16'h0000;
        tick(); tick();
        chk("reset_outs", st(), E_IDLE);
        chk("reset_mem", mfld(), 5'b00000);
        chk("reset_pcaddr", pc_addr_o, 16'h0000);

        // ALU + write-back, no PC jump, readys high
        alu_en = 1'b1; wreg_en = 1'b1; instr_rdy = 1'b1; mem_rdy = 1'b1;
        setpc = 2'b00; pc = 16'h1234; setpc_addr = 16'h0042;
        rst_n = 1'b1;
        chk("idle_after_release", st(), E_IDLE);
        tick(); chk("t2_fetch", st(), E_FETCH);
        tick(); chk("t2_decode", st(), E_DEC);
        tick(); chk("t2_alu", st(), E_ALU);
        tick(); chk("t2_wreg", st(), E_WREG);
        tick(); chk("t2_updpc", st(), E_UPD);
        chk("t2_pcaddr", pc_addr_o, 16'h0000);

        // two memory phases, offset jump wrapping past 2^16
        instr_rdy = 1'b0; alu_en = 1'b0; wreg_en = 1'b0; mem_en = 2'b11;
        mem_sel = 4'b1001; mem_wr = 2'b10; mem_rdy = 1'b0;
        setpc = 2'b01; pc = 16'hFFF0; setpc_addr = 16'h0020;
        tick(); chk("t3_fetch", st(), E_FETCH);
        chk("t3_pcaddr_clr", pc_addr_o, 16'h0000);
        tick(); chk("t3_fetch_wait", st(), E_FETCH);
        instr_rdy = 1'b1;
        tick(); chk("t3_decode", st(), E_DEC);
        tick(); chk("t3_mem0", st(), E_MEM);
        chk("t3_mem0_fld", mfld(), 5'b01000);
        for (int i = 0; i < 3; i++) begin
            tick(); chk("t3_mem0_wait", st(), E_MEM);
            chk("t3_mem0_wait_fld", mfld(), 5'b01000);
        end
        mem_rdy = 1'b1;
        tick(); chk("t3_mem1", st(), E_MEM);
        chk("t3_mem1_fld", mfld(), 5'b10101);
        tick(); chk("t4_updpc_off", st(), E_UPDJ);
        chk("t4_off_addr", pc_addr_o, 16'h0010);

        // stall at instruction boundary
        stall = 1'b1; setpc = 2'b10; setpc_addr = 16'h3000; mem_en = 2'b00;
        tick(); chk("t5_stall", st(), E_STALL);
        tick(); chk("t5_stall_hold", st(), E_STALL);
        stall = 1'b0; instr_rdy = 1'b0;
        tick(); chk("t5_stall_exit", st(), E_FETCH);

        // enable low freezes; ready pulse seen while frozen is lost
        en = 1'b0; instr_rdy = 1'b1;
        tick(); chk("t5_en_freeze", st(), E_FETCH);
        en = 1'b1; instr_rdy = 1'b0;
        tick(); chk("t5_pulse_lost", st(), E_FETCH);
        instr_rdy = 1'b1;
        tick(); chk("t5_decode", st(), E_DEC);
        tick(); chk("t4_updpc_dir", st(), E_UPDJ);
        chk("t4_dir_addr", pc_addr_o, 16'h3000);
        tick(); chk("t4_after_upd", st(), E_FETCH);
        chk("t4_after_upd_addr", pc_addr_o, 16'h0000);

        // asynchronous reset in the middle of a memory wait
        mem_en = 2'b01; mem_rdy = 1'b0;
        tick(); chk("t1_decode", st(), E_DEC);
        tick(); chk("t1_mem", st(), E_MEM);
        #2 rst_n = 1'b0;
        #1 chk("t1_async_rst", st(), E_IDLE);
        chk("t1_async_rst_mem", mfld(), 5'b00000);
        #2 rst_n = 1'b1;
        chk("t1_idle", st(), E_IDLE);
        tick(); chk("t1_fetch", st(), E_FETCH);

        // data memory never ready
        tick(); chk("t6_decode", st(), E_DEC);
        tick(); chk("t6_mem", st(), E_MEM);
        repeat (7) tick();
        chk("t6_before_limit", st(), E_MEM);
        tick();
`ifdef CTRL_SEQ_MEM_TIMEOUT_EN
        chk("t6_err", st(), E_ERR);
        repeat (5) tick();
        chk("t6_err_sticky", st(), E_ERR);
`else
        chk("t6_no_err", st(), E_MEM);
        repeat (20) tick();
        chk("t6_no_err_late", st(), E_MEM);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end
endmodule
